// File: rtl/predicate_setp_unit_if.sv
// Request, control and predicate-write bundle for predicate_setp_unit.
// The unit sits on the slave side. Whatever feeds it and consumes its
// predicate write port sits on the master side.
interface predicate_setp_unit_if #(
  parameter int DATA_W  = 32,
  parameter int PRED_AW = 4
);
  localparam int NUM_PRED = 2 ** PRED_AW;

  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_a;
  logic [DATA_W-1:0]   in_b;
  logic [2:0]          in_op;
  logic                in_neg;
  logic [PRED_AW-1:0]  in_dst;
  logic                wb_stall;
  logic                pred_we;
  logic [PRED_AW-1:0]  pred_waddr;
  logic                pred_wdata;
  logic [NUM_PRED-1:0] busy_mask;

  modport master (
    output flush, in_valid, in_a, in_b, in_op, in_neg, in_dst, wb_stall,
    input  in_ready, pred_we, pred_waddr, pred_wdata, busy_mask
  );

  modport slave (
    input  flush, in_valid, in_a, in_b, in_op, in_neg, in_dst, wb_stall,
    output in_ready, pred_we, pred_waddr, pred_wdata, busy_mask
  );
endinterface

// File: rtl/predicate_setp_unit.sv
// Two-stage set-predicate unit. S1 captures the operands. The compare is
// evaluated out of S1 and captured in S2. S2 drives the single write port of
// the predicate register file. busy_mask lists every destination that still
// has a write pending in S1 or S2.
module predicate_setp_unit #(
  parameter int DATA_W  = 32,
  parameter int PRED_AW = 4
) (
  input logic                  clk,
  input logic                  reset,
  predicate_setp_unit_if.slave bus
);
  localparam int NUM_PRED = 2 ** PRED_AW;

  typedef enum logic [2:0] {
    OP_EQ    = 3'b000,
    OP_NE    = 3'b001,
    OP_LT    = 3'b010,
    OP_LE    = 3'b011,
    OP_LTU   = 3'b100,
    OP_LEU   = 3'b101,
    OP_TRUE  = 3'b110,
    OP_FALSE = 3'b111
  } cmp_op_e;

  logic                s1_valid;
  logic [DATA_W-1:0]   s1_a;
  logic [DATA_W-1:0]   s1_b;
  cmp_op_e             s1_op;
  logic                s1_neg;
  logic [PRED_AW-1:0]  s1_dst;
  logic                s1_res;

  logic                s2_valid;
  logic                s2_res;
  logic [PRED_AW-1:0]  s2_dst;

  logic [NUM_PRED-1:0] busy;

  // Stage 1 captures the operands on an accept. It holds everything while
  // the write port is stalled. It empties on flush or when nothing is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_EQ;
      s1_neg   <= 1'b0;
      s1_dst   <= '0;
    end else if (bus.flush) begin
      s1_valid <= 1'b0;
    end else if (!bus.wb_stall) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a   <= bus.in_a;
        s1_b   <= bus.in_b;
        s1_op  <= cmp_op_e'(bus.in_op);
        s1_neg <= bus.in_neg;
        s1_dst <= bus.in_dst;
      end
    end
  end

  // Evaluate the compare on the S1 operands. The signed opcodes treat the
  // operands as two's complement across the full width.
  always_comb begin
    s1_res = 1'b0;
    case (s1_op)
      OP_EQ:    s1_res = (s1_a == s1_b);
      OP_NE:    s1_res = (s1_a != s1_b);
      OP_LT:    s1_res = ($signed(s1_a) <  $signed(s1_b));
      OP_LE:    s1_res = ($signed(s1_a) <= $signed(s1_b));
      OP_LTU:   s1_res = (s1_a <  s1_b);
      OP_LEU:   s1_res = (s1_a <= s1_b);
      OP_TRUE:  s1_res = 1'b1;
      OP_FALSE: s1_res = 1'b0;
      default:  s1_res = 1'b0;
    endcase
    s1_res = s1_res ^ s1_neg;
  end

  // Stage 2 takes the result and destination from S1. Result and destination
  // load only for a real op, so the write port keeps its last address/data
  // while bubbles pass through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_res   <= 1'b0;
      s2_dst   <= '0;
    end else if (bus.flush) begin
      s2_valid <= 1'b0;
    end else if (!bus.wb_stall) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_res <= s1_res;
        s2_dst <= s1_dst;
      end
    end
  end

  // Mark every destination that still has a write pending in either stage.
  always_comb begin
    busy = '0;
    if (s1_valid) busy[s1_dst] = 1'b1;
    if (s2_valid) busy[s2_dst] = 1'b1;
  end

  assign bus.in_ready   = ~bus.wb_stall;
  assign bus.pred_we    = s2_valid & ~bus.wb_stall & ~bus.flush;
  assign bus.pred_waddr = s2_dst;
  assign bus.pred_wdata = s2_res;
  assign bus.busy_mask  = busy;
endmodule

// File: tb/tb_predicate_setp_unit.sv
// Self-checking bench for predicate_setp_unit. Directed scenarios cover the
// latency, compare flavours, streaming, stall, flush and asynchronous reset.
// A randomized run is then compared against a queue-based model of the
// in-flight ops.
module tb_predicate_setp_unit;
  localparam int DATA_W   = 32;
  localparam int PRED_AW  = 4;
  localparam int NUM_PRED = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  predicate_setp_unit_if #(.DATA_W(DATA_W), .PRED_AW(PRED_AW)) bus ();

  predicate_setp_unit #(.DATA_W(DATA_W), .PRED_AW(PRED_AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Model: each op waiting to be written, tagged with the pipeline stage it occupies.
  typedef struct {
    logic [3:0] dst;
    logic       res;
    int         stage;
  } flight_t;

  flight_t inflight[$];

  logic                exp_we;
  logic                exp_wdata;
  logic [3:0]          exp_waddr;
  logic [NUM_PRED-1:0] exp_busy;

  function automatic logic ref_result(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] op, input logic neg);
    logic r;
    case (op)
      3'd0:    r = (a == b);
      3'd1:    r = (a != b);
      3'd2:    r = ($signed(a) <  $signed(b));
      3'd3:    r = ($signed(a) <= $signed(b));
      3'd4:    r = (a <  b);
      3'd5:    r = (a <= b);
      3'd6:    r = 1'b1;
      default: r = 1'b0;
    endcase
    return r ^ neg;
  endfunction

  // Advance the model by one clock edge, using the inputs presented before that edge.
  function automatic void model_edge();
    flight_t nxt[$];
    if (reset || bus.flush) begin
      inflight.delete();
      return;
    end
    if (bus.wb_stall) return;
    foreach (inflight[i]) begin
      if (inflight[i].stage == 1) begin
        flight_t e;
        e = inflight[i];
        e.stage = 2;
        nxt.push_back(e);
      end
    end
    if (bus.in_valid)
      nxt.push_back('{dst: bus.in_dst,
                      res: ref_result(bus.in_a, bus.in_b, bus.in_op, bus.in_neg),
                      stage: 1});
    inflight = nxt;
  endfunction

  // Derive the expected combinational outputs for the current cycle.
  function automatic void model_expect();
    logic cand;
    cand      = 1'b0;
    exp_busy  = '0;
    exp_waddr = '0;
    exp_wdata = 1'b0;
    foreach (inflight[i]) begin
      exp_busy[inflight[i].dst] = 1'b1;
      if (inflight[i].stage == 2) begin
        cand      = 1'b1;
        exp_waddr = inflight[i].dst;
        exp_wdata = inflight[i].res;
      end
    end
    exp_we = cand & ~bus.wb_stall & ~bus.flush & ~reset;
  endfunction

  task automatic set_in(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic neg, input logic [3:0] dst);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_neg   = neg;
    bus.in_dst   = dst;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 4;
    if (bus.pred_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_we: got %b expected 0", bus.pred_we); end
    if (bus.pred_waddr !== 4'd0) begin failures++; $display("[TB] FAIL reset_waddr: got %0d expected 0", bus.pred_waddr); end
    if (bus.pred_wdata !== 1'b0) begin failures++; $display("[TB] FAIL reset_wdata: got %b expected 0", bus.pred_wdata); end
    if (bus.busy_mask !== 16'h0) begin failures++; $display("[TB] FAIL reset_busy: got %h expected 0000", bus.busy_mask); end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.in_ready); end
    tick();
  endtask

  task automatic test_basic_latency();
    set_in(1'b1, 32'd5, 32'd5, 3'd0, 1'b0, 4'd3);
    tick();
    set_in(1'b0, '0, '0, 3'd0, 1'b0, 4'd0);
    @(negedge clk);
    checks += 2;
    if (bus.pred_we !== 1'b0) begin failures++; $display("[TB] FAIL lat_we_c1: got %b expected 0", bus.pred_we); end
    if (bus.busy_mask !== 16'h0008) begin failures++; $display("[TB] FAIL lat_busy_c1: got %h expected 0008", bus.busy_mask); end
    tick();
    @(negedge clk);
    checks += 4;
    if (bus.pred_we !== 1'b1) begin failures++; $display("[TB] FAIL lat_we_c2: got %b expected 1", bus.pred_we); end
    if (bus.pred_waddr !== 4'd3) begin failures++; $display("[TB] FAIL lat_waddr: got %0d expected 3", bus.pred_waddr); end
    if (bus.pred_wdata !== 1'b1) begin failures++; $display("[TB] FAIL lat_wdata: got %b expected 1", bus.pred_wdata); end
    if (bus.busy_mask !== 16'h0008) begin failures++; $display("[TB] FAIL lat_busy_c2: got %h expected 0008", bus.busy_mask); end
    tick();
    @(negedge clk);
    checks += 2;
    if (bus.pred_we !== 1'b0) begin failures++; $display("[TB] FAIL lat_we_c3: got %b expected 0", bus.pred_we); end
    if (bus.busy_mask !== 16'h0) begin failures++; $display("[TB] FAIL lat_busy_c3: got %h expected 0000", bus.busy_mask); end
    tick();
  endtask

  task automatic test_signed_unsigned();
    logic [2:0] ops[3]  = '{3'd2, 3'd4, 3'd4};
    logic       negs[3] = '{1'b0, 1'b0, 1'b1};
    logic       want[3] = '{1'b1, 1'b0, 1'b1};
    int n = 0;
    for (int c = 0; c < 7; c++) begin
      if (c < 3) set_in(1'b1, 32'hFFFF_FFFF, 32'd1, ops[c], negs[c], 4'(c + 1));
      else       set_in(1'b0, '0, '0, 3'd0, 1'b0, 4'd0);
      @(negedge clk);
      if (bus.pred_we === 1'b1) begin
        if (n < 3) begin
          checks++;
          if (bus.pred_wdata !== want[n]) begin
            failures++;
            $display("[TB] FAIL sgn_wdata[%0d]: got %b expected %b", n, bus.pred_wdata, want[n]);
          end
        end
        n++;
      end
      tick();
    end
    checks++;
    if (n != 3) begin failures++; $display("[TB] FAIL sgn_count: got %0d writes expected 3", n); end
  endtask

  task automatic test_streaming();
    logic [2:0]  ops[4]  = '{3'd6, 3'd7, 3'd1, 3'd3};
    logic [31:0] av[4]   = '{32'd0, 32'd0, 32'd7, 32'd2};
    logic [31:0] bv[4]   = '{32'd0, 32'd0, 32'd7, 32'd2};
    logic        want[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int n = 0;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) set_in(1'b1, av[c], bv[c], ops[c], 1'b0, 4'(c));
      else       set_in(1'b0, '0, '0, 3'd0, 1'b0, 4'd0);
      @(negedge clk);
      if (c < 4) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL stream_ready c%0d: got %b expected 1", c, bus.in_ready); end
      end
      if (bus.pred_we === 1'b1) begin
        if (n < 4) begin
          checks += 3;
          if (c != n + 2) begin failures++; $display("[TB] FAIL stream_cycle[%0d]: got %0d expected %0d", n, c, n + 2); end
          if (bus.pred_waddr !== 4'(n)) begin failures++; $display("[TB] FAIL stream_waddr[%0d]: got %0d expected %0d", n, bus.pred_waddr, n); end
          if (bus.pred_wdata !== want[n]) begin failures++; $display("[TB] FAIL stream_wdata[%0d]: got %b expected %b", n, bus.pred_wdata, want[n]); end
        end
        n++;
      end
      tick();
    end
    checks++;
    if (n != 4) begin failures++; $display("[TB] FAIL stream_count: got %0d writes expected 4", n); end
  endtask

  task automatic test_stall();
    set_in(1'b1, 32'd1, 32'd2, 3'd6, 1'b0, 4'd9);
    tick();
    set_in(1'b0, '0, '0, 3'd0, 1'b0, 4'd0);
    tick();
    bus.wb_stall = 1'b1;
    set_in(1'b1, 32'd3, 32'd3, 3'd0, 1'b0, 4'd12);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks += 4;
      if (bus.pred_we !== 1'b0) begin failures++; $display("[TB] FAIL stall_we k%0d: got %b expected 0", k, bus.pred_we); end
      if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_ready k%0d: got %b expected 0", k, bus.in_ready); end
      if (bus.busy_mask[9] !== 1'b1) begin failures++; $display("[TB] FAIL stall_busy9 k%0d: got %b expected 1", k, bus.busy_mask[9]); end
      if (bus.busy_mask[12] !== 1'b0) begin failures++; $display("[TB] FAIL stall_busy12 k%0d: got %b expected 0", k, bus.busy_mask[12]); end
      tick();
    end
    bus.wb_stall = 1'b0;
    set_in(1'b0, '0, '0, 3'd0, 1'b0, 4'd0);
    @(negedge clk);
    checks += 3;
    if (bus.pred_we !== 1'b1) begin failures++; $display("[TB] FAIL stall_release_we: got %b expected 1", bus.pred_we); end
    if (bus.pred_waddr !== 4'd9) begin failures++; $display("[TB] FAIL stall_release_waddr: got %0d expected 9", bus.pred_waddr); end
    if (bus.pred_wdata !== 1'b1) begin failures++; $display("[TB] FAIL stall_release_wdata: got %b expected 1", bus.pred_wdata); end
    tick();
    @(negedge clk);
    checks += 2;
    if (bus.pred_we !== 1'b0) begin failures++; $display("[TB] FAIL stall_after_we: got %b expected 0", bus.pred_we); end
    if (bus.busy_mask !== 16'h0) begin failures++; $display("[TB] FAIL stall_after_busy: got %h expected 0000", bus.busy_mask); end
    tick();
  endtask

  task automatic test_flush();
    set_in(1'b1, 32'd1, 32'd1, 3'd0, 1'b0, 4'd4);
    tick();
    set_in(1'b1, 32'd1, 32'd1, 3'd0, 1'b0, 4'd5);
    tick();
    bus.flush = 1'b1;
    set_in(1'b1, 32'd0, 32'd0, 3'd6, 1'b0, 4'd6);
    @(negedge clk);
    checks += 2;
    if (bus.pred_we !== 1'b0) begin failures++; $display("[TB] FAIL flush_we: got %b expected 0", bus.pred_we); end
    if (bus.busy_mask !== 16'h0030) begin failures++; $display("[TB] FAIL flush_busy_pre: got %h expected 0030", bus.busy_mask); end
    tick();
    bus.flush = 1'b0;
    set_in(1'b0, '0, '0, 3'd0, 1'b0, 4'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks += 2;
      if (bus.pred_we !== 1'b0) begin failures++; $display("[TB] FAIL flush_post_we k%0d: got %b expected 0", k, bus.pred_we); end
      if (bus.busy_mask !== 16'h0) begin failures++; $display("[TB] FAIL flush_post_busy k%0d: got %h expected 0000", k, bus.busy_mask); end
      tick();
    end
    set_in(1'b1, 32'd0, 32'd0, 3'd6, 1'b0, 4'd7);
    tick();
    set_in(1'b0, '0, '0, 3'd0, 1'b0, 4'd0);
    tick();
    @(negedge clk);
    checks += 3;
    if (bus.pred_we !== 1'b1) begin failures++; $display("[TB] FAIL flush_new_we: got %b expected 1", bus.pred_we); end
    if (bus.pred_waddr !== 4'd7) begin failures++; $display("[TB] FAIL flush_new_waddr: got %0d expected 7", bus.pred_waddr); end
    if (bus.pred_wdata !== 1'b1) begin failures++; $display("[TB] FAIL flush_new_wdata: got %b expected 1", bus.pred_wdata); end
    tick();
  endtask

  task automatic test_async_reset();
    set_in(1'b1, 32'd0, 32'd0, 3'd6, 1'b0, 4'd2);
    tick();
    set_in(1'b1, 32'd0, 32'd0, 3'd7, 1'b0, 4'd10);
    tick();
    set_in(1'b0, '0, '0, 3'd0, 1'b0, 4'd0);
    #2;
    checks += 2;
    if (bus.pred_we !== 1'b1) begin failures++; $display("[TB] FAIL arst_pre_we: got %b expected 1", bus.pred_we); end
    if (bus.busy_mask !== 16'h0404) begin failures++; $display("[TB] FAIL arst_pre_busy: got %h expected 0404", bus.busy_mask); end
    reset = 1'b1;
    #1;
    inflight.delete();
    checks += 2;
    if (bus.pred_we !== 1'b0) begin failures++; $display("[TB] FAIL arst_we: got %b expected 0", bus.pred_we); end
    if (bus.busy_mask !== 16'h0) begin failures++; $display("[TB] FAIL arst_busy: got %h expected 0000", bus.busy_mask); end
    tick();
    #3;
    reset = 1'b0;
    set_in(1'b1, 32'd0, 32'd0, 3'd6, 1'b0, 4'd11);
    tick();
    set_in(1'b0, '0, '0, 3'd0, 1'b0, 4'd0);
    @(negedge clk);
    checks += 2;
    if (bus.pred_we !== 1'b0) begin failures++; $display("[TB] FAIL arst_lat_we1: got %b expected 0", bus.pred_we); end
    if (bus.busy_mask !== 16'h0800) begin failures++; $display("[TB] FAIL arst_lat_busy: got %h expected 0800", bus.busy_mask); end
    tick();
    @(negedge clk);
    checks += 2;
    if (bus.pred_we !== 1'b1) begin failures++; $display("[TB] FAIL arst_lat_we2: got %b expected 1", bus.pred_we); end
    if (bus.pred_waddr !== 4'd11) begin failures++; $display("[TB] FAIL arst_lat_waddr: got %0d expected 11", bus.pred_waddr); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int c = 0; c < 400; c++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a + 32'd1;
        2:       begin a = 32'h8000_0000; b = $urandom; end
        default: b = $urandom;
      endcase
      if (c < 390) begin
        set_in(($urandom_range(0, 3) != 0), a, b, 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        bus.wb_stall = ($urandom_range(0, 4) == 0);
        bus.flush    = ($urandom_range(0, 15) == 0);
      end else begin
        set_in(1'b0, '0, '0, 3'd0, 1'b0, 4'd0);
        bus.wb_stall = 1'b0;
        bus.flush    = 1'b0;
      end
      @(negedge clk);
      model_expect();
      checks += 3;
      if (bus.in_ready !== ~bus.wb_stall) begin failures++; $display("[TB] FAIL rnd_ready c%0d: got %b expected %b", c, bus.in_ready, ~bus.wb_stall); end
      if (bus.pred_we !== exp_we) begin failures++; $display("[TB] FAIL rnd_we c%0d: got %b expected %b", c, bus.pred_we, exp_we); end
      if (bus.busy_mask !== exp_busy) begin failures++; $display("[TB] FAIL rnd_busy c%0d: got %h expected %h", c, bus.busy_mask, exp_busy); end
      if (exp_we) begin
        checks += 2;
        if (bus.pred_waddr !== exp_waddr) begin failures++; $display("[TB] FAIL rnd_waddr c%0d: got %0d expected %0d", c, bus.pred_waddr, exp_waddr); end
        if (bus.pred_wdata !== exp_wdata) begin failures++; $display("[TB] FAIL rnd_wdata c%0d: got %b expected %b", c, bus.pred_wdata, exp_wdata); end
      end
      tick();
    end
  endtask

  // Hold reset, then run each scenario in turn and report.
  initial begin
    reset        = 1'b1;
    bus.flush    = 1'b0;
    bus.wb_stall = 1'b0;
    set_in(1'b0, '0, '0, 3'd0, 1'b0, 4'd0);
    test_reset();
    test_basic_latency();
    test_signed_unsigned();
    test_streaming();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
